// File: rtl/periph_bus_pkg.sv
// Shared types and slot map for the peripheral bus sequencer.
// Slot numbers follow addr[31:24] of the core data port.
package periph_bus_pkg;

  localparam int SLOT_W = 8;

  localparam logic [SLOT_W-1:0] SLOT_MEM     = 8'd0;
  localparam logic [SLOT_W-1:0] SLOT_UART_RX = 8'd5;
  localparam logic [SLOT_W-1:0] SLOT_UART_TX = 8'd6;

  localparam logic [SLOT_W-1:0] DEF_SLOT_MASK =
    (SLOT_W'(1) << SLOT_MEM) |
    (SLOT_W'(1) << SLOT_UART_RX) |
    (SLOT_W'(1) << SLOT_UART_TX);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } bus_state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_txn_t;

endpackage

// File: rtl/periph_bus_ctrl_tmr.sv
// Saturating access timer for the peripheral bus sequencer.
// expire_o is high on the last cycle allowed before a bus error.
module bus_timeout_cnt #(
  parameter  int TIMEOUT = 16,
  localparam int CW      = $clog2(TIMEOUT) + 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/periph_bus_ctrl.sv
// Core data port to peripheral slot sequencer (IDLE/ACCESS/DONE).
// Optional BUS_ERR_IRQ_EN adds a sticky bus-error IRQ with fault address.
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int                   NUM_SLOTS = 8,
  parameter logic [NUM_SLOTS-1:0] SLOT_MASK = DEF_SLOT_MASK,
  parameter int                   TIMEOUT   = 16,
  parameter logic [31:0]          ERR_RDATA = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     core_req_i,
  input  logic                     core_we_i,
  input  logic [3:0]               core_be_i,
  input  logic [31:0]              core_addr_i,
  input  logic [31:0]              core_wdata_i,
  output logic [31:0]              core_rdata_o,
  output logic                     core_stall_o,
  output logic                     core_err_o,
  output logic [NUM_SLOTS-1:0]     periph_req_o,
  output logic                     periph_we_o,
  output logic [3:0]               periph_be_o,
  output logic [31:0]              periph_addr_o,
  output logic [31:0]              periph_wdata_o,
  input  logic [NUM_SLOTS*32-1:0]  periph_rdata_i,
  input  logic [NUM_SLOTS-1:0]     periph_ready_i
`ifdef BUS_ERR_IRQ_EN
  ,
  output logic                     err_irq_o,
  input  logic                     err_clr_i,
  output logic [31:0]              err_addr_o
`endif
);

  bus_state_t state_q, state_d;
  bus_txn_t   txn_q, txn_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [SLOT_W-1:0]    slot;
  logic [NUM_SLOTS-1:0] sel_oh;
  logic                 ready_sel;
  logic [31:0]          rdata_sel;
  logic                 addr_hit;
  logic                 tmr_clr;
  logic                 tmr_en;
  logic                 tmr_exp;

  assign slot = txn_q.addr[31:24];

  always_comb begin
    sel_oh    = '0;
    ready_sel = 1'b0;
    rdata_sel = '0;
    addr_hit  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (core_addr_i[31:24] == SLOT_W'(i)) begin
        addr_hit = SLOT_MASK[i];
      end
      if (slot == SLOT_W'(i)) begin
        sel_oh[i] = 1'b1;
        ready_sel = periph_ready_i[i];
        rdata_sel = periph_rdata_i[32*i +: 32];
      end
    end
  end

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  always_comb begin
    state_d      = state_q;
    txn_d        = txn_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    core_stall_o = 1'b0;
    core_err_o   = 1'b0;
    periph_req_o = '0;
    tmr_clr      = 1'b1;
    tmr_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by reset so the core is released while rstn_i is low.
        core_stall_o = core_req_i & rstn_i;
        if (core_req_i) begin
          txn_d.we    = core_we_i;
          txn_d.be    = core_be_i;
          txn_d.addr  = core_addr_i;
          txn_d.wdata = core_wdata_i;
          if (addr_hit) begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        core_stall_o = 1'b1;
        periph_req_o = sel_oh;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b1;
        if (ready_sel) begin
          rdata_d = txn_q.we ? 32'h0 : rdata_sel;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (tmr_exp) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        core_err_o = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      txn_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign core_rdata_o   = rdata_q;
  assign periph_we_o    = txn_q.we;
  assign periph_be_o    = txn_q.be;
  assign periph_addr_o  = {8'd0, txn_q.addr[23:0]};
  assign periph_wdata_o = txn_q.wdata;

`ifdef BUS_ERR_IRQ_EN
  logic        irq_q, irq_d;
  logic [31:0] eaddr_q, eaddr_d;
  logic        done_err;

  assign done_err = (state_q == DONE) && err_q;

  // A clear in the same cycle as a new error re-arms on the new address.
  always_comb begin
    irq_d   = irq_q;
    eaddr_d = eaddr_q;
    if (done_err) begin
      irq_d = 1'b1;
      if (!irq_q || err_clr_i) begin
        eaddr_d = txn_q.addr;
      end
    end else if (err_clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      irq_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      irq_q   <= irq_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign err_irq_o  = irq_q;
  assign err_addr_o = eaddr_q;
`endif

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed self-checking bench for periph_bus_ctrl.
// Define BUS_ERR_IRQ_EN to also cover the error IRQ ports.
module tb_periph_bus_ctrl;

  logic         clk_i;
  logic         rstn_i;
  logic         core_req_i;
  logic         core_we_i;
  logic [3:0]   core_be_i;
  logic [31:0]  core_addr_i;
  logic [31:0]  core_wdata_i;
  logic [31:0]  core_rdata_o;
  logic         core_stall_o;
  logic         core_err_o;
  logic [7:0]   periph_req_o;
  logic         periph_we_o;
  logic [3:0]   periph_be_o;
  logic [31:0]  periph_addr_o;
  logic [31:0]  periph_wdata_o;
  logic [255:0] periph_rdata_i;
  logic [7:0]   periph_ready_i;
  logic         err_irq_o;
  logic         err_clr_i;
  logic [31:0]  err_addr_o;

  int n_chk;
  int n_fail;

  periph_bus_ctrl dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .core_req_i     (core_req_i),
    .core_we_i      (core_we_i),
    .core_be_i      (core_be_i),
    .core_addr_i    (core_addr_i),
    .core_wdata_i   (core_wdata_i),
    .core_rdata_o   (core_rdata_o),
    .core_stall_o   (core_stall_o),
    .core_err_o     (core_err_o),
    .periph_req_o   (periph_req_o),
    .periph_we_o    (periph_we_o),
    .periph_be_o    (periph_be_o),
    .periph_addr_o  (periph_addr_o),
    .periph_wdata_o (periph_wdata_o),
    .periph_rdata_i (periph_rdata_i),
    .periph_ready_i (periph_ready_i)
`ifdef BUS_ERR_IRQ_EN
    ,
    .err_irq_o      (err_irq_o),
    .err_clr_i      (err_clr_i),
    .err_addr_o     (err_addr_o)
`endif
  );

`ifndef BUS_ERR_IRQ_EN
  assign err_irq_o  = 1'b0;
  assign err_addr_o = 32'h0;
`endif

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] a,
                     input logic        we,
                     input logic [3:0]  be,
                     input logic [31:0] wd);
    core_req_i   = 1'b1;
    core_addr_i  = a;
    core_we_i    = we;
    core_be_i    = be;
    core_wdata_i = wd;
  endtask

  int  n_req;
  bit  seen;
  int  cyc;

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rstn_i         = 1'b0;
    core_req_i     = 1'b0;
    core_we_i      = 1'b0;
    core_be_i      = 4'h0;
    core_addr_i    = 32'h0;
    core_wdata_i   = 32'h0;
    periph_rdata_i = '0;
    periph_ready_i = '0;
    err_clr_i      = 1'b0;

    #3;
    chk("rst_stall", 32'(core_stall_o), 32'h0);
    chk("rst_req", 32'(periph_req_o), 32'h0);
    chk("rst_rdata", core_rdata_o, 32'h0);
    chk("rst_err", 32'(core_err_o), 32'h0);
    chk("rst_addr", periph_addr_o, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // zero-wait read from data memory
    req(32'h0000_0010, 1'b0, 4'hF, 32'h0);
    periph_rdata_i[31:0] = 32'hCAFE_F00D;
    periph_ready_i       = 8'h01;
    #1;
    chk("rd_idle_stall", 32'(core_stall_o), 32'h1);
    tick();
    core_req_i = 1'b0;
    chk("rd_acc_req", 32'(periph_req_o), 32'h01);
    chk("rd_acc_stall", 32'(core_stall_o), 32'h1);
    chk("rd_acc_addr", periph_addr_o, 32'h0000_0010);
    tick();
    periph_ready_i = 8'h00;
    chk("rd_done_stall", 32'(core_stall_o), 32'h0);
    chk("rd_done_rdata", core_rdata_o, 32'hCAFE_F00D);
    chk("rd_done_err", 32'(core_err_o), 32'h0);
    chk("rd_done_req", 32'(periph_req_o), 32'h0);
    tick();
    chk("rd_hold_rdata", core_rdata_o, 32'hCAFE_F00D);

    // write to UART TX, ready in third access cycle
    periph_rdata_i[223:192] = 32'h1234_5678;
    req(32'h0600_0000, 1'b1, 4'b0001, 32'h41);
    tick();
    core_req_i     = 1'b0;
    periph_ready_i = 8'h01;
    chk("wr_c1_req", 32'(periph_req_o), 32'h40);
    chk("wr_wdata", periph_wdata_o, 32'h41);
    chk("wr_be", 32'(periph_be_o), 32'h1);
    chk("wr_we", 32'(periph_we_o), 32'h1);
    chk("wr_paddr", periph_addr_o, 32'h0);
    tick();
    periph_ready_i = 8'h00;
    chk("wr_c2_req", 32'(periph_req_o), 32'h40);
    tick();
    periph_ready_i = 8'h40;
    chk("wr_c3_req", 32'(periph_req_o), 32'h40);
    tick();
    periph_ready_i = 8'h00;
    chk("wr_done_err", 32'(core_err_o), 32'h0);
    chk("wr_done_rdata", core_rdata_o, 32'h0);
    chk("wr_done_stall", 32'(core_stall_o), 32'h0);
    tick();

    // ready on the timeout cycle still succeeds
    periph_rdata_i[191:160] = 32'h55AA_1234;
    req(32'h0500_0000, 1'b0, 4'hF, 32'h0);
    tick();
    core_req_i = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    periph_ready_i = 8'h20;
    chk("edge_req", 32'(periph_req_o), 32'h20);
    tick();
    periph_ready_i = 8'h00;
    chk("edge_err", 32'(core_err_o), 32'h0);
    chk("edge_rdata", core_rdata_o, 32'h55AA_1234);
    tick();

    // unmapped slot 3
    req(32'h0300_0000, 1'b0, 4'hF, 32'h0);
    #1;
    chk("um_idle_stall", 32'(core_stall_o), 32'h1);
    chk("um_idle_req", 32'(periph_req_o), 32'h0);
    tick();
    core_req_i = 1'b0;
    chk("um_done_stall", 32'(core_stall_o), 32'h0);
    chk("um_done_err", 32'(core_err_o), 32'h1);
    chk("um_done_rdata", core_rdata_o, 32'h0);
    chk("um_done_req", 32'(periph_req_o), 32'h0);
    tick();
    chk("um_err_pulse", 32'(core_err_o), 32'h0);

    // slot 8 is beyond NUM_SLOTS
    req(32'h0800_0000, 1'b0, 4'hF, 32'h0);
    tick();
    core_req_i = 1'b0;
    chk("s8_err", 32'(core_err_o), 32'h1);
    tick();

    // UART RX never ready: timeout
    req(32'h0500_0000, 1'b0, 4'hF, 32'h0);
    tick();
    core_req_i = 1'b0;
    n_req = 0;
    seen  = 1'b0;
    cyc   = 0;
    while (!seen && cyc < 40) begin
      if (periph_req_o[5]) n_req++;
      if (core_err_o) seen = 1'b1;
      else tick();
      cyc++;
    end
    chk("to_err_seen", 32'(seen), 32'h1);
    chk("to_req_cycles", 32'(n_req), 32'd16);
    chk("to_rdata", core_rdata_o, 32'h0);
    tick();

    // asynchronous reset mid-access
    req(32'h0000_0020, 1'b0, 4'hF, 32'h0);
    tick();
    chk("ar_pre_req", 32'(periph_req_o), 32'h01);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("ar_req", 32'(periph_req_o), 32'h0);
    chk("ar_stall", 32'(core_stall_o), 32'h0);
    chk("ar_paddr", periph_addr_o, 32'h0);
    #2;
    rstn_i = 1'b1;
    #1;
    chk("ar_fresh_stall", 32'(core_stall_o), 32'h1);
    chk("ar_fresh_req", 32'(periph_req_o), 32'h0);
    periph_rdata_i[31:0] = 32'h0BAD_BEEF;
    periph_ready_i       = 8'h01;
    tick();
    core_req_i = 1'b0;
    chk("ar_acc_req", 32'(periph_req_o), 32'h01);
    chk("ar_acc_addr", periph_addr_o, 32'h0000_0020);
    tick();
    periph_ready_i = 8'h00;
    chk("ar_done_rdata", core_rdata_o, 32'h0BAD_BEEF);
    chk("ar_done_err", 32'(core_err_o), 32'h0);
    tick();

`ifdef BUS_ERR_IRQ_EN
    chk("irq_rst", 32'(err_irq_o), 32'h0);
    req(32'h0700_0004, 1'b0, 4'hF, 32'h0);
    tick();
    core_req_i = 1'b0;
    chk("irq_err1", 32'(core_err_o), 32'h1);
    tick();
    chk("irq_set", 32'(err_irq_o), 32'h1);
    chk("irq_addr1", err_addr_o, 32'h0700_0004);
    req(32'h0300_0008, 1'b0, 4'hF, 32'h0);
    tick();
    core_req_i = 1'b0;
    err_clr_i  = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("irq_clr_vs_err", 32'(err_irq_o), 32'h1);
    chk("irq_addr2", err_addr_o, 32'h0300_0008);
    req(32'h0400_000C, 1'b0, 4'hF, 32'h0);
    tick();
    core_req_i = 1'b0;
    tick();
    chk("irq_first_wins", err_addr_o, 32'h0300_0008);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    chk("irq_clr", 32'(err_irq_o), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
